// File: rtl/mask_pkg.sv
// Shared types for the mask stream decoder slice.
// Optional feature macro: MASK_THERMO_EN (thermometer masks).
package mask_pkg;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERMO = 1'b1
    } mask_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } mask_state_e;

endpackage

// File: rtl/mask_segment_gen.sv
// Combinational generator for one SegW-bit slice of the expanded mask.
// Global bit b = idx*SegW + j; one-hot sets b == code, thermometer sets b >= code.
// The thermometer compare is only built when MASK_THERMO_EN is defined.
module mask_segment_gen #(
    parameter int unsigned Width = 256,
    parameter int unsigned SegW  = 32,
    localparam int unsigned CodeW = $clog2(Width),
    localparam int unsigned NBeat = Width / SegW,
    localparam int unsigned IdxW  = (NBeat > 1) ? $clog2(NBeat) : 1
) (
    input  logic [CodeW-1:0] code_i,
    input  logic             mode_i,
    input  logic [IdxW-1:0]  idx_i,
    output logic [SegW-1:0]  seg_o
);

    logic [CodeW:0] code_ext;

    assign code_ext = {1'b0, code_i};

`ifndef MASK_THERMO_EN
    logic unused_mode;
    assign unused_mode = mode_i;
`endif

    for (genvar j = 0; j < SegW; j++) begin : g_bit
        logic [CodeW:0] bit_pos;

        assign bit_pos = (CodeW+1)'(idx_i) * (CodeW+1)'(SegW) + (CodeW+1)'(j);

`ifdef MASK_THERMO_EN
        assign seg_o[j] = mode_i ? (bit_pos >= code_ext) : (bit_pos == code_ext);
`else
        assign seg_o[j] = (bit_pos == code_ext);
`endif
    end

endmodule

// File: rtl/mask_stream_decoder.sv
// Expands a CodeW-bit code into a Width-bit one-hot or thermometer mask and
// streams it as NBeat registered SegW-bit beats over valid/ready.
// Optional feature macro: MASK_THERMO_EN (honour mode_i; otherwise one-hot only).
module mask_stream_decoder
    import mask_pkg::*;
#(
    parameter int unsigned Width = 256,
    parameter int unsigned SegW  = 32,
    localparam int unsigned CodeW = $clog2(Width),
    localparam int unsigned NBeat = Width / SegW,
    localparam int unsigned IdxW  = (NBeat > 1) ? $clog2(NBeat) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CodeW-1:0] code_i,
    input  logic             mode_i,
    input  logic             code_valid_i,
    output logic             code_ready_o,
    output logic [SegW-1:0]  seg_o,
    output logic [IdxW-1:0]  seg_idx_o,
    output logic             seg_last_o,
    output logic             seg_valid_o,
    input  logic             seg_ready_i,
    output logic             busy_o
);

    mask_state_e      state_q, state_d;
    logic [CodeW-1:0] code_q, code_d;
    mask_mode_e       mode_q, mode_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [SegW-1:0]  seg_q, seg_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    logic             code_acc;
    logic             beat_acc;
    mask_mode_e       mode_in;
    logic [IdxW-1:0]  idx_nxt;
    logic [CodeW-1:0] gen_code;
    mask_mode_e       gen_mode;
    logic [IdxW-1:0]  gen_idx;
    logic [SegW-1:0]  gen_seg;

`ifdef MASK_THERMO_EN
    assign mode_in = mask_mode_e'(mode_i);
`else
    logic unused_mode_i;
    assign unused_mode_i = mode_i;
    assign mode_in       = MODE_ONEHOT;
`endif

    assign beat_acc     = valid_q && seg_ready_i;
    assign code_ready_o = (state_q == ST_IDLE) || (beat_acc && last_q);
    assign code_acc     = code_valid_i && code_ready_o;
    assign idx_nxt      = idx_q + IdxW'(1);

    // A single generator serves both the first beat of a newly accepted code
    // and the following beat of the current mask, so back-to-back masks need
    // no extra cycle.
    assign gen_code = code_acc ? code_i : code_q;
    assign gen_mode = code_acc ? mode_in : mode_q;
    assign gen_idx  = code_acc ? '0 : idx_nxt;

    mask_segment_gen #(
        .Width (Width),
        .SegW  (SegW)
    ) u_seg_gen (
        .code_i (gen_code),
        .mode_i (gen_mode == MODE_THERMO),
        .idx_i  (gen_idx),
        .seg_o  (gen_seg)
    );

    // Next-state and next-beat selection for the stream FSM.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (code_acc) begin
            state_d = ST_STREAM;
            code_d  = code_i;
            mode_d  = mode_in;
            idx_d   = '0;
            seg_d   = gen_seg;
            last_d  = (NBeat == 1);
            valid_d = 1'b1;
        end else if (beat_acc) begin
            if (last_q) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                seg_d   = '0;
                last_d  = 1'b0;
                valid_d = 1'b0;
            end else begin
                idx_d  = idx_nxt;
                seg_d  = gen_seg;
                last_d = (idx_nxt == IdxW'(NBeat - 1));
            end
        end
    end

    // State, latched code and output beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            mode_q  <= MODE_ONEHOT;
            idx_q   <= '0;
            seg_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign seg_o       = seg_q;
    assign seg_idx_o   = idx_q;
    assign seg_last_o  = last_q;
    assign seg_valid_o = valid_q;
    assign busy_o      = (state_q == ST_STREAM);

endmodule

// File: tb/tb_mask_stream_decoder.sv
// Scoreboard bench for mask_stream_decoder (Width=256, SegW=32).
// Expected beats are queued by the stimulus; a negedge monitor pops and
// compares on every handshake and checks stability during stalls.
// Thermometer expectations apply only when MASK_THERMO_EN is defined.
module tb_mask_stream_decoder;

    typedef struct {
        logic [31:0] seg;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

`ifdef MASK_THERMO_EN
    localparam bit ThermoEn = 1'b1;
`else
    localparam bit ThermoEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  code_i;
    logic        mode_i;
    logic        code_valid_i;
    logic        code_ready_o;
    logic [31:0] seg_o;
    logic [2:0]  seg_idx_o;
    logic        seg_last_o;
    logic        seg_valid_o;
    logic        seg_ready_i;
    logic        busy_o;

    beat_t       sb[$];
    int          hs_cyc[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] tab [8];

    mask_stream_decoder #(
        .Width (256),
        .SegW  (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_i       (code_i),
        .mode_i       (mode_i),
        .code_valid_i (code_valid_i),
        .code_ready_o (code_ready_o),
        .seg_o        (seg_o),
        .seg_idx_o    (seg_idx_o),
        .seg_last_o   (seg_last_o),
        .seg_valid_o  (seg_valid_o),
        .seg_ready_i  (seg_ready_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference expressed per beat: which beat the code falls in, and a shifted fill.
    function automatic logic [31:0] model_seg(input int code, input bit mode, input int idx);
        logic [31:0] s;
        s = '0;
        if (mode && ThermoEn) begin
            if (idx * 32 >= code) s = '1;
            else if (idx * 32 + 31 >= code) begin
                s = '1;
                s = s << (code - idx * 32);
            end
        end else if (code / 32 == idx) begin
            s[code % 32] = 1'b1;
        end
        return s;
    endfunction

    task automatic push_tab(input logic [31:0] t [8]);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.seg  = t[i];
            b.idx  = 3'(i);
            b.last = (i == 7);
            sb.push_back(b);
        end
    endtask

    task automatic push_model(input int code, input bit mode);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.seg  = model_seg(code, mode, i);
            b.idx  = 3'(i);
            b.last = (i == 7);
            sb.push_back(b);
        end
    endtask

    // Called in the posedge+1 phase; returns in the posedge+1 phase after acceptance.
    task automatic send(input logic [7:0] c, input logic m);
        bit done;
        done         = 1'b0;
        code_i       = c;
        mode_i       = m;
        code_valid_i = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (code_ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        code_valid_i = 1'b0;
        n_checks++;
        if (done) n_pass++;
        else $display("FAIL code_accept: code %0d not accepted within 300 cycles, expected acceptance", c);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            if (sb.size() == 0 && !busy_o) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (done) n_pass++;
        else $display("FAIL %s: %0d beats still pending, busy=%0b, expected drained", name, sb.size(), busy_o);
    endtask

    // Downstream ready: constant high, or randomly stalling.
    initial begin
        seg_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            seg_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: compare handshaken beats with the scoreboard, check stall stability.
    initial begin
        bit          prev_stall;
        logic [31:0] p_seg;
        logic [2:0]  p_idx;
        logic        p_last;
        beat_t       e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_stable", {28'd0, seg_o, seg_idx_o, seg_last_o},
                        {28'd0, p_seg, p_idx, p_last});
                if (seg_valid_o && seg_ready_i) begin
                    hs_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got idx %0d seg %h, expected no beat", seg_idx_o, seg_o);
                    end else begin
                        e = sb.pop_front();
                        chk("seg",  64'(seg_o),      64'(e.seg));
                        chk("idx",  64'(seg_idx_o),  64'(e.idx));
                        chk("last", 64'(seg_last_o), 64'(e.last));
                    end
                end
                prev_stall = seg_valid_o && !seg_ready_i;
                p_seg  = seg_o;
                p_idx  = seg_idx_o;
                p_last = seg_last_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n        = 1'b0;
        code_i       = '0;
        mode_i       = 1'b0;
        code_valid_i = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg",   64'(seg_o),        64'd0);
        chk("rst_idx",   64'(seg_idx_o),    64'd0);
        chk("rst_last",  64'(seg_last_o),   64'd0);
        chk("rst_valid", 64'(seg_valid_o),  64'd0);
        chk("rst_busy",  64'(busy_o),       64'd0);
        chk("rst_ready", 64'(code_ready_o), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-hot code 77 with latency check on the first beat
        tab = '{32'h0, 32'h0, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        push_tab(tab);
        code_i = 8'd77; mode_i = 1'b0; code_valid_i = 1'b1;
        @(negedge clk);
        chk("pre_accept_valid", 64'(seg_valid_o),  64'd0);
        chk("pre_accept_ready", 64'(code_ready_o), 64'd1);
        @(posedge clk);
        #1 code_valid_i = 1'b0;
        @(negedge clk);
        chk("latency_valid", 64'(seg_valid_o), 64'd1);
        chk("latency_busy",  64'(busy_o),      64'd1);
        @(posedge clk);
        #1;
        wait_drain("drain_77");
        chk("idle_valid", 64'(seg_valid_o), 64'd0);

        // Mode 1 codes: thermometer if built, one-hot otherwise
        if (ThermoEn) begin
            tab = '{32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
            push_tab(tab);
            tab = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
            push_tab(tab);
        end else begin
            tab = '{32'h0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
            push_tab(tab);
            tab = '{32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
            push_tab(tab);
        end
        tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000};
        push_tab(tab);
        send(8'd40, 1'b1);
        send(8'd0, 1'b1);
        send(8'd255, 1'b1);
        wait_drain("drain_mode1");

        // Random downstream stalls
        hs_cyc.delete();
        rand_ready = 1'b1;
        push_model(130, 1'b1);
        push_model(31, 1'b0);
        push_model(32, 1'b1);
        push_model(77, 1'b0);
        send(8'd130, 1'b1);
        send(8'd31, 1'b0);
        send(8'd32, 1'b1);
        send(8'd77, 1'b0);
        wait_drain("drain_stall");
        chk("stall_handshakes", 64'(hs_cyc.size()), 64'd32);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back masks with no bubble
        hs_cyc.delete();
        push_model(3, 1'b0);
        push_model(200, 1'b0);
        send(8'd3, 1'b0);
        send(8'd200, 1'b0);
        wait_drain("drain_b2b");
        chk("b2b_count", 64'(hs_cyc.size()), 64'd16);
        if (hs_cyc.size() == 16)
            chk("b2b_span", 64'(hs_cyc[15] - hs_cyc[0]), 64'd15);

        // Reset in the middle of a mask
        push_model(100, 1'b0);
        send(8'd100, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (seg_valid_o && seg_idx_o == 3'd4) found = 1'b1;
        end
        chk("reach_beat4", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_seg",   64'(seg_o),       64'd0);
        chk("mid_rst_idx",   64'(seg_idx_o),   64'd0);
        chk("mid_rst_valid", 64'(seg_valid_o), 64'd0);
        chk("mid_rst_busy",  64'(busy_o),      64'd0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc.delete();
        push_model(5, 1'b1);
        send(8'd5, 1'b1);
        wait_drain("drain_after_rst");
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_handshakes", 64'(hs_cyc.size()), 64'd8);
        chk("post_rst_idle_valid", 64'(seg_valid_o), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
